timer_ctrl: RTL and testbench

Command sequencer between the CPU and the `timer` display-clock block. It turns a single packed "set time" command into the timer's per-digit register writes, after checking the value is a legal 24-hour time. It turns a "get time" command into a coherent multi-digit read that retries if the clock rolls over mid-read. It is the only master of the timer's CPU port.

---
 rtl/timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_timer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Command sequencer for the timer's CPU port: validated per-digit time writes
// and coherent multi-digit reads that retry when the minute rolls over mid-read.
module timer_ctrl #(
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_set,
  input  logic        cmd_get,
  input  logic [12:0] set_time,
  output logic [12:0] get_time,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        tmr_sel,
  output logic        tmr_we,
  output logic [1:0]  tmr_addr,
  output logic [3:0]  tmr_wdata,
  input  logic [3:0]  tmr_rdata
);

  localparam int unsigned TIME_W  = 13;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  state_t             state;
  logic [2:0]         beat;
  logic [RETRY_W-1:0] retry;
  logic [TIME_W-1:0]  set_q;
  logic [3:0]         cap_m0;
  logic [2:0]         cap_m1;
  logic [3:0]         cap_h0;
  logic [1:0]         cap_h1;

  // Digit of a packed time for a timer address, zero-extended to 4 bits.
  function automatic logic [3:0] wr_digit(input logic [TIME_W-1:0] t, input logic [1:0] a);
    case (a)
      2'd3:    return {2'b00, t[12:11]};
      2'd2:    return t[10:7];
      2'd1:    return {1'b0, t[6:4]};
      default: return t[3:0];
    endcase
  endfunction

  function automatic logic legal(input logic [TIME_W-1:0] t);
    return (t[12:11] <= 2'd2) && (t[10:7] <= 4'd9) && (t[6:4] <= 3'd5) &&
           (t[3:0] <= 4'd9) && !((t[12:11] == 2'd2) && (t[10:7] > 4'd3));
  endfunction

  // FIN is the done cycle; it accepts commands exactly like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      retry     <= '0;
      set_q     <= '0;
      cap_m0    <= '0;
      cap_m1    <= '0;
      cap_h0    <= '0;
      cap_h1    <= '0;
      get_time  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tmr_sel   <= 1'b0;
      tmr_we    <= 1'b0;
      tmr_addr  <= '0;
      tmr_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (cmd_set) begin
            if (legal(set_time)) begin
              set_q     <= set_time;
              err       <= 1'b0;
              busy      <= 1'b1;
              tmr_sel   <= 1'b1;
              tmr_we    <= 1'b1;
              tmr_addr  <= 2'd3;
              tmr_wdata <= wr_digit(set_time, 2'd3);
              beat      <= '0;
              state     <= WR;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end else if (cmd_get) begin
            err      <= 1'b0;
            busy     <= 1'b1;
            tmr_sel  <= 1'b1;
            tmr_we   <= 1'b0;
            tmr_addr <= 2'd0;
            beat     <= '0;
            retry    <= '0;
            state    <= RD;
          end
        end

        WR: begin
          if (beat == 3'd3) begin
            tmr_sel <= 1'b0;
            tmr_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            beat      <= beat + 3'd1;
            tmr_addr  <= tmr_addr - 2'd1;
            tmr_wdata <= wr_digit(set_q, tmr_addr - 2'd1);
          end
        end

        RD: begin
          // rdata on the bus now belongs to the beat issued one cycle earlier
          case (beat)
            3'd1:    cap_m0 <= tmr_rdata;
            3'd2:    cap_m1 <= tmr_rdata[2:0];
            3'd3:    cap_h0 <= tmr_rdata;
            3'd4:    cap_h1 <= tmr_rdata[1:0];
            default: ;
          endcase
          if (beat < 3'd4) begin
            beat     <= beat + 3'd1;
            tmr_addr <= (beat == 3'd3) ? 2'd0 : 2'(beat + 3'd1);
          end else if (beat == 3'd4) begin
            beat    <= 3'd5;
            tmr_sel <= 1'b0;
          end else if ((tmr_rdata == cap_m0) || (retry == RETRY_W'(RETRY_MAX))) begin
            get_time <= {cap_h1, cap_h0, cap_m1, tmr_rdata};
            err      <= (tmr_rdata != cap_m0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else begin
            retry    <= retry + RETRY_W'(1);
            beat     <= '0;
            tmr_sel  <= 1'b1;
            tmr_addr <= 2'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a small behavioural timer digit store.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_set = 1'b0;
  logic        cmd_get = 1'b0;
  logic [12:0] set_time = '0;
  logic [12:0] get_time;
  logic        busy, done, err, tmr_sel, tmr_we;
  logic [1:0]  tmr_addr;
  logic [3:0]  tmr_wdata;
  logic [3:0]  tmr_rdata;

  int errors = 0;
  int checks = 0;
  int beats = 0;
  int done_cnt = 0;
  int mode = 0;
  logic rolled;
  logic [3:0] mem [4];

  timer_ctrl #(.RETRY_MAX(3)) dut (
    .clk(clk), .rst(rst), .cmd_set(cmd_set), .cmd_get(cmd_get),
    .set_time(set_time), .get_time(get_time), .busy(busy), .done(done),
    .err(err), .tmr_sel(tmr_sel), .tmr_we(tmr_we), .tmr_addr(tmr_addr),
    .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata)
  );

  always #10 clk = ~clk;

  // Timer model: registered read data; mode 1 rolls 12:39 to 12:40 once, mode 2 bumps MIN0 on each MIN0 read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
      tmr_rdata <= 4'd0;
      rolled    <= 1'b0;
    end else if (tmr_sel) begin
      beats <= beats + 1;
      if (tmr_we) begin
        mem[tmr_addr] <= tmr_wdata;
      end else begin
        tmr_rdata <= mem[tmr_addr];
        if (tmr_addr == 2'd0 && mode == 1 && !rolled) begin
          mem[0] <= 4'd0;
          mem[1] <= 4'd4;
          rolled <= 1'b1;
        end else if (tmr_addr == 2'd0 && mode == 2) begin
          mem[0] <= (mem[0] == 4'd9) ? 4'd0 : mem[0] + 4'd1;
        end
      end
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  function automatic logic [12:0] tm(input int h1, input int h0, input int m1, input int m0);
    return {2'(h1), 4'(h0), 3'(m1), 4'(m0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns the cycle (command cycle = 0) in which done is seen, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_set(input logic [12:0] t);
    int n;
    set_time = t;
    cmd_set  = 1'b1;
    tick();
    cmd_set  = 1'b0;
    wait_done(n);
    chk("setup_set_done_cycle", 16'(n), 16'd5);
    tick();
  endtask

  logic [1:0] rd_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] wr_addr [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [3:0] wr_data [4] = '{4'd2, 4'd3, 4'd5, 4'd9};

  initial begin
    int n;
    int b0;
    int d0;

    // Reset values and quiet bus
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_outputs", {busy, done, err, tmr_sel, tmr_we, tmr_addr, tmr_wdata}, 16'd0);
    chk("rst_get_time", 16'(get_time), 16'd0);
    repeat (20) tick();
    chk("idle_no_beats", 16'(beats), 16'd0);

    // Valid set 23:59
    set_time = tm(2, 3, 5, 9);
    cmd_set  = 1'b1;
    tick();
    cmd_set  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("set_beat%0d", i), {busy, done, tmr_sel, tmr_we, 6'd0, tmr_addr, tmr_wdata},
          {1'b1, 1'b0, 1'b1, 1'b1, 6'd0, wr_addr[i], wr_data[i]});
      tick();
    end
    chk("set_done_c5", {busy, done, err, tmr_sel}, 16'b0100);
    chk("set_mem", {mem[3], mem[2], mem[1], mem[0]}, 16'h2359);
    tick();
    chk("set_done_pulse", 16'(done), 16'd0);

    // Rejected sets: 24:00 then 12:60
    b0 = beats;
    set_time = tm(2, 4, 0, 0);
    cmd_set  = 1'b1;
    tick();
    cmd_set  = 1'b0;
    chk("rej24_c1", {busy, done, err, tmr_sel}, 16'b0110);
    tick();
    chk("rej24_c2_err_held", {done, err}, 16'b01);
    set_time = tm(1, 2, 6, 0);
    cmd_set  = 1'b1;
    tick();
    cmd_set  = 1'b0;
    chk("rej60_c1", {busy, done, err, tmr_sel}, 16'b0110);
    repeat (3) tick();
    chk("rej_no_beats", 16'(beats - b0), 16'd0);

    // Stable get at 12:34, with a dropped cmd_set in cycle 3
    do_set(tm(1, 2, 3, 4));
    cmd_get = 1'b1;
    tick();
    cmd_get = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("get_beat%0d", i), {busy, tmr_sel, tmr_we, 11'd0, tmr_addr}, {3'b110, 11'd0, rd_seq[i]});
      if (i == 2) begin
        set_time = tm(0, 0, 0, 0);
        cmd_set  = 1'b1;
      end
      tick();
      cmd_set = 1'b0;
    end
    chk("get_drain_c6", {busy, done, tmr_sel}, 16'b100);
    tick();
    chk("get_done_c7", {busy, done, err}, 16'b010);
    chk("get_time_1234", 16'(get_time), 16'(tm(1, 2, 3, 4)));
    tick();
    chk("get_set_dropped", {mem[3], mem[2], mem[1], mem[0]}, 16'h1234);

    // Rollover between MIN0 reads: one retry
    do_set(tm(1, 2, 3, 9));
    mode = 1;
    cmd_get = 1'b1;
    tick();
    cmd_get = 1'b0;
    wait_done(n);
    chk("roll_done_cycle", 16'(n), 16'd13);
    chk("roll_err", 16'(err), 16'd0);
    chk("roll_get_time", 16'(get_time), 16'(tm(1, 2, 4, 0)));
    tick();
    mode = 0;

    // Retries exhausted
    do_set(tm(1, 2, 3, 4));
    mode = 2;
    cmd_get = 1'b1;
    tick();
    cmd_get = 1'b0;
    wait_done(n);
    chk("exh_done_cycle", 16'(n), 16'd25);
    chk("exh_err", 16'(err), 16'd1);
    chk("exh_get_time", 16'(get_time), 16'(tm(1, 2, 3, 1)));
    tick();
    mode = 0;
    chk("exh_err_held", {done, err}, 16'b01);

    // Reset in cycle 2 of a set
    set_time = tm(2, 3, 5, 9);
    cmd_set  = 1'b1;
    tick();
    cmd_set  = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outputs", {busy, done, err, tmr_sel, tmr_we, tmr_addr, tmr_wdata}, 16'd0);
    chk("mid_rst_get_time", 16'(get_time), 16'd0);
    b0 = beats;
    d0 = done_cnt;
    repeat (10) tick();
    chk("mid_rst_no_beats", 16'(beats - b0), 16'd0);
    chk("mid_rst_no_done", 16'(done_cnt - d0), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
